// File: rtl/dmem_responder.sv
// Data-side memory responder: single-outstanding req/addr_ok/data_ok slave.
// Byte-lane writes and full-word reads commit LATENCY edges after acceptance.

module dmem_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    input  logic [7:0]            wbyte_i,
    output logic [7:0]            rbyte_o
);
    logic [7:0] ram_q [2**ADDR_WIDTH];
    logic [7:0] rbyte_q;

    // Storage is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (we_i) ram_q[idx_i] <= wbyte_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rbyte_q <= '0;
        else if (re_i) rbyte_q <= ram_q[idx_i];
    end

    assign rbyte_o = rbyte_q;
endmodule

module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic                      wr;
        logic [NUM_LANES-1:0]      wen;
        logic [ADDR_WIDTH-1:0]     idx;
        logic [NUM_LANES-1:0][7:0] wdata;
    } req_t;

    state_e                    state_q;
    logic [3:0]                cnt_q;
    logic                      addr_ok_q;
    logic                      data_ok_q;
    req_t                      req_q;
    req_t                      req_in;
    req_t                      req_d;
    logic                      commit;
    logic [NUM_LANES-1:0][7:0] rdata_lane;
    logic                      unused_addr;

    always_comb begin
        req_in       = '0;
        req_in.wr    = data_wr;
        req_in.wen   = data_wen;
        req_in.idx   = data_addr[ADDR_WIDTH+1:2];
        req_in.wdata = data_wdata;
    end

    assign unused_addr = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

    // With LATENCY==1 the commit edge is the acceptance edge, so the live
    // inputs must feed the lanes instead of the not-yet-loaded capture.
    assign req_d  = (state_q == IDLE) ? req_in : req_q;
    assign commit = ((state_q == IDLE) && data_req && (LATENCY == 1)) ||
                    ((state_q == BUSY) && (cnt_q == 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_ok_q <= 1'b1;
            data_ok_q <= 1'b0;
            req_q     <= '0;
        end else begin
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (data_req) begin
                        req_q <= req_in;
                        if (LATENCY == 1) begin
                            state_q   <= DONE;
                            data_ok_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end else begin
                        addr_ok_q <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= DONE;
                        data_ok_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    addr_ok_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    addr_ok_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we_i    (commit & req_d.wr & req_d.wen[i]),
            .re_i    (commit & ~req_d.wr),
            .idx_i   (req_d.idx),
            .wbyte_i (req_d.wdata[i]),
            .rbyte_o (rdata_lane[i])
        );
    end

    assign data_addr_ok = addr_ok_q;
    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_lane;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) driven by directed
// and random transactions, checked against a word-level memory model.

module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       req;
    logic [2:0]       wr_s;
    logic [2:0][3:0]  wen_s;
    logic [2:0][31:0] addr_s;
    logic [2:0][31:0] wdata_s;
    wire  [2:0]       addr_ok;
    wire  [2:0]       data_ok;
    wire  [2:0][31:0] rdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [int];
    logic [31:0] last_rd [3];

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_wr(wr_s[0]), .data_wen(wen_s[0]),
        .data_addr(addr_s[0]), .data_wdata(wdata_s[0]), .data_addr_ok(addr_ok[0]),
        .data_data_ok(data_ok[0]), .data_rdata(rdata[0]));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_wr(wr_s[1]), .data_wen(wen_s[1]),
        .data_addr(addr_s[1]), .data_wdata(wdata_s[1]), .data_addr_ok(addr_ok[1]),
        .data_data_ok(data_ok[1]), .data_rdata(rdata[1]));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .data_req(req[2]), .data_wr(wr_s[2]), .data_wen(wen_s[2]),
        .data_addr(addr_s[2]), .data_wdata(wdata_s[2]), .data_addr_ok(addr_ok[2]),
        .data_data_ok(data_ok[2]), .data_rdata(rdata[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge; returns at the negedge where data_ok was seen.
    task automatic txn(input int k, input bit wr, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic aok);
        int n;
        n = 0;
        while (!addr_ok[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        req[k] = 1'b1; wr_s[k] = wr; wen_s[k] = wen; addr_s[k] = addr; wdata_s[k] = wdata;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        wr_s[k] = 1'($urandom); wen_s[k] = 4'($urandom);
        addr_s[k] = $urandom; wdata_s[k] = $urandom;
        lat = -1; rd = 'x; aok = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (data_ok[k]) begin
                lat = c; rd = rdata[k]; aok = addr_ok[k];
                break;
            end
        end
    endtask

    task automatic do_op(input int k, input bit wr, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag, output logic [31:0] rd);
        int lat;
        logic a;
        int key;
        logic [31:0] mask, old;
        key = k * 4096 + int'(addr[11:2]);
        txn(k, wr, wen, addr, wdata, lat, rd, a);
        check({tag, ".lat"}, lat, lat_of(k));
        check({tag, ".aok_in_done"}, {31'd0, a}, 32'd0);
        if (wr) begin
            mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
            old  = mdl.exists(key) ? mdl[key] : 32'h0;
            mdl[key] = (old & ~mask) | (wdata & mask);
            check({tag, ".rd_hold"}, rd, last_rd[k]);
        end else begin
            old = mdl.exists(key) ? mdl[key] : 32'hx;
            check({tag, ".rd"}, rd, old);
            last_rd[k] = old;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int pool [6];
        int cnt;
        logic [31:0] a;
        rst = 3'b111; req = '0; wr_s = '0; wen_s = '0; addr_s = '0; wdata_s = '0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d.aok", k), {31'd0, addr_ok[k]}, 32'd1);
            check($sformatf("rst%0d.dok", k), {31'd0, data_ok[k]}, 32'd0);
            check($sformatf("rst%0d.rdata", k), rdata[k], 32'h0);
        end
        rst = 3'b000;
        @(negedge clk);

        // Full-word and byte-lane behaviour on the single-cycle instance.
        do_op(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, "w10", rd);
        do_op(0, 0, 4'b0000, 32'h10, 32'h0, "r10", rd);
        check("r10.const", rd, 32'hDEADBEEF);
        do_op(0, 1, 4'b1111, 32'h20, 32'h11223344, "w20", rd);
        do_op(0, 1, 4'b0010, 32'h21, 32'hAAAAAAAA, "w21_b1", rd);
        do_op(0, 0, 4'b1111, 32'h20, 32'h0, "r20a", rd);
        check("r20a.const", rd, 32'h1122AA44);
        do_op(0, 1, 4'b1100, 32'h20, 32'h55665566, "w20_hi", rd);
        do_op(0, 0, 4'b0000, 32'h20, 32'h0, "r20b", rd);
        check("r20b.const", rd, 32'h5566AA44);
        do_op(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, "w20_none", rd);
        do_op(0, 0, 4'b0000, 32'h20, 32'h0, "r20c", rd);
        check("r20c.const", rd, 32'h5566AA44);

        // Index wrap and ignored byte-offset bits.
        do_op(0, 1, 4'b1111, 32'h0000_1004, 32'h12345678, "w1004", rd);
        do_op(0, 0, 4'b0000, 32'h0000_0004, 32'h0, "r0004", rd);
        check("r0004.const", rd, 32'h12345678);
        do_op(0, 0, 4'b0000, 32'h0000_0007, 32'h0, "r0007", rd);
        check("r0007.const", rd, 32'h12345678);

        // Read data holds across a write and idle cycles.
        do_op(0, 0, 4'b0000, 32'h10, 32'h0, "hold_r", rd);
        do_op(0, 1, 4'b1111, 32'h14, 32'h0BB0_0BB0, "hold_w", rd);
        check("hold_w.const", rd, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold_idle%0d", i), rdata[0], 32'hDEADBEEF);
        end

        // LATENCY=3 with req held high: accept every 4 cycles, data_ok 3 later.
        do_op(1, 1, 4'b1111, 32'h30, 32'hA5A5_3C3C, "l3_w30", rd);
        @(negedge clk);
        req[1] = 1'b1; wr_s[1] = 1'b0; wen_s[1] = 4'b0; addr_s[1] = 32'h30; wdata_s[1] = 32'h0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("l3_thru%0d.aok", i), {31'd0, addr_ok[1]}, {31'd0, (i % 4 == 0)});
            check($sformatf("l3_thru%0d.dok", i), {31'd0, data_ok[1]}, {31'd0, (i % 4 == 3)});
            if (i % 4 == 3) check($sformatf("l3_thru%0d.rd", i), rdata[1], 32'hA5A5_3C3C);
            @(negedge clk);
        end
        req[1] = 1'b0;
        last_rd[1] = 32'hA5A5_3C3C;

        // Reset in the middle of a LATENCY=4 write discards it.
        do_op(2, 1, 4'b1111, 32'h40, 32'h0BADC0DE, "l4_w40", rd);
        do_op(2, 0, 4'b0000, 32'h40, 32'h0, "l4_r40", rd);
        @(negedge clk);
        check("l4_pre.aok", {31'd0, addr_ok[2]}, 32'd1);
        req[2] = 1'b1; wr_s[2] = 1'b1; wen_s[2] = 4'b1111; addr_s[2] = 32'h40; wdata_s[2] = 32'hCAFEF00D;
        @(posedge clk);
        #1 req[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        check("midrst.aok", {31'd0, addr_ok[2]}, 32'd1);
        check("midrst.dok", {31'd0, data_ok[2]}, 32'd0);
        check("midrst.rdata", rdata[2], 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        last_rd[2] = 32'h0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_ok[2]) cnt++;
        end
        check("midrst.no_dok", cnt, 0);
        do_op(2, 0, 4'b0000, 32'h40, 32'h0, "midrst.r40", rd);
        check("midrst.r40.const", rd, 32'h0BADC0DE);

        // Random traffic over a small preloaded pool of words per instance.
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 6; p++) begin
                pool[p] = int'($urandom_range(1023, 0));
                do_op(k, 1, 4'b1111, 32'(pool[p]) << 2, $urandom, $sformatf("pre%0d_%0d", k, p), rd);
            end
            for (int j = 0; j < 30; j++) begin
                a = ($urandom & 32'hFFFF_F003) | (32'(pool[$urandom_range(5, 0)]) << 2);
                do_op(k, 1'($urandom), 4'($urandom), a, $urandom, $sformatf("rnd%0d_%0d", k, j), rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
